// File: rtl/demux_4.sv
// demux_4: registered 1-to-4 demultiplexer.
// Routes din onto the lane chosen by A and drives the other three lanes to
// zero. en low clears every lane. sel_oh flags the active lane even when the
// routed data is zero. Y and sel_oh come straight from flops, so consumers
// never see a glitch while A or din are changing.
module demux_4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         A,
  input  logic [WIDTH-1:0]   din,
  output logic [4*WIDTH-1:0] Y,
  output logic [3:0]         sel_oh
);

  localparam int NUM_LANES = 4;

  logic [4*WIDTH-1:0] y_d,      y_q;
  logic [3:0]         sel_oh_d, sel_oh_q;

  // Next-state decode: place din on the selected lane, zero on the others.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a bit unassigned and no latch is inferred.
    y_d      = '0;
    sel_oh_d = '0;
    if (en) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (A == 2'(k)) begin
          y_d[k*WIDTH +: WIDTH] = din;
          sel_oh_d[k]           = 1'b1;
        end
      end
    end
  end

  // Output registers. Reset has priority over en, A and din.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of its input, independent of statement order.
    if (rst) begin
      y_q      <= '0;
      sel_oh_q <= '0;
    end else begin
      y_q      <= y_d;
      sel_oh_q <= sel_oh_d;
    end
  end

  assign Y      = y_q;
  assign sel_oh = sel_oh_q;

endmodule

// File: tb/tb_demux_4.sv
// Self-checking bench for demux_4. Two instances: WIDTH=1 (n_*) and WIDTH=8
// (w_*). A vector table covers reset, the select sweep, zero data, enable
// gating and a mid-stream reset. A hand-written sequence covers the wide
// lane handoff. Randomized traffic on both instances is then compared with
// an arithmetic reference model.
module tb_demux_4;

  logic        clk;

  logic        n_rst, n_en, n_din;
  logic [1:0]  n_a;
  logic [3:0]  n_y;
  logic [3:0]  n_sel;

  logic        w_rst, w_en;
  logic [1:0]  w_a;
  logic [7:0]  w_din;
  logic [31:0] w_y;
  logic [3:0]  w_sel;

  int n_checks = 0;
  int n_fail   = 0;

  demux_4 #(.WIDTH(1)) u_narrow (
    .clk(clk), .rst(n_rst), .en(n_en), .A(n_a), .din(n_din),
    .Y(n_y), .sel_oh(n_sel)
  );

  demux_4 #(.WIDTH(8)) u_wide (
    .clk(clk), .rst(w_rst), .en(w_en), .A(w_a), .din(w_din),
    .Y(w_y), .sel_oh(w_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [1:0] a;
    logic       din;
    logic [3:0] exp_y;
    logic [3:0] exp_sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic en, logic [1:0] a,
                              logic din, logic [3:0] exp_y, logic [3:0] exp_sel);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en; v.a = a; v.din = din;
    v.exp_y = exp_y; v.exp_sel = exp_sel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Reference model: data shifted to lane a by plain arithmetic, or zero.
  function automatic logic [31:0] ref_y(int width, logic rst, logic en,
                                        logic [1:0] a, logic [7:0] d);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    if (rst || !en) return 32'd0;
    return (32'(d) & mask) << (int'(a) * width);
  endfunction

  function automatic logic [3:0] ref_sel(logic rst, logic en, logic [1:0] a);
    if (rst || !en) return 4'd0;
    return 4'(1 << int'(a));
  endfunction

  function automatic int busy_lanes(logic [31:0] y);
    int c = 0;
    for (int k = 0; k < 4; k++) if (y[k*8 +: 8] != 8'd0) c++;
    return c;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b1; n_en = 1'b0; n_a = 2'd0; n_din = 1'b0;
    w_rst = 1'b1; w_en = 1'b0; w_a = 2'd0; w_din = 8'd0;

    vecs.push_back(mk("rst_cycle0",    1, 1, 2'd2, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk("rst_cycle1",    1, 1, 2'd2, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk("sweep_a0",      0, 1, 2'd0, 1, 4'b0001, 4'b0001));
    vecs.push_back(mk("sweep_a1",      0, 1, 2'd1, 1, 4'b0010, 4'b0010));
    vecs.push_back(mk("sweep_a2",      0, 1, 2'd2, 1, 4'b0100, 4'b0100));
    vecs.push_back(mk("sweep_a3",      0, 1, 2'd3, 1, 4'b1000, 4'b1000));
    vecs.push_back(mk("zero_data_a1",  0, 1, 2'd1, 0, 4'b0000, 4'b0010));
    vecs.push_back(mk("en_gate_on",    0, 1, 2'd3, 1, 4'b1000, 4'b1000));
    vecs.push_back(mk("en_gate_off",   0, 0, 2'd3, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk("mid_a0",        0, 1, 2'd0, 1, 4'b0001, 4'b0001));
    vecs.push_back(mk("mid_a1",        0, 1, 2'd1, 1, 4'b0010, 4'b0010));
    vecs.push_back(mk("mid_rst_a2",    1, 1, 2'd2, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk("mid_resume_a3", 0, 1, 2'd3, 1, 4'b1000, 4'b1000));

    // Narrow instance: table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      n_rst = vecs[i].rst; n_en = vecs[i].en; n_a = vecs[i].a;
      n_din = vecs[i].din;
      tick();
      check({vecs[i].name, "_y"},   32'(n_y),   32'(vecs[i].exp_y));
      check({vecs[i].name, "_sel"}, 32'(n_sel), 32'(vecs[i].exp_sel));
      w_rst = 1'b0;
    end

    // Wide instance: reset, then lane 2 hands off to lane 0 with no overlap.
    w_rst = 1'b1; w_en = 1'b1; w_a = 2'd1; w_din = 8'hFF;
    tick();
    check("wide_rst_y",   w_y,          32'h0000_0000);
    check("wide_rst_sel", 32'(w_sel),   32'h0);
    w_rst = 1'b0; w_a = 2'd2; w_din = 8'hA5;
    tick();
    check("wide_a2_y",    w_y,          32'h00A5_0000);
    check("wide_a2_sel",  32'(w_sel),   32'h4);
    check("wide_a2_lanes", 32'(busy_lanes(w_y)), 32'd1);
    w_a = 2'd0; w_din = 8'h3C;
    tick();
    check("wide_a0_y",    w_y,          32'h0000_003C);
    check("wide_a0_sel",  32'(w_sel),   32'h1);
    check("wide_a0_lanes", 32'(busy_lanes(w_y)), 32'd1);
    w_a = 2'd3; w_din = 8'h00;
    tick();
    check("wide_zero_y",  w_y,          32'h0000_0000);
    check("wide_zero_sel", 32'(w_sel),  32'h8);

    // Randomized traffic on both instances against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] exp_ny, exp_wy;
      logic [3:0]  exp_ns, exp_ws;
      n_rst = ($urandom_range(0, 15) == 0);
      n_en  = ($urandom_range(0, 4) != 0);
      n_a   = 2'($urandom_range(0, 3));
      n_din = 1'($urandom);
      w_rst = ($urandom_range(0, 15) == 0);
      w_en  = ($urandom_range(0, 4) != 0);
      w_a   = 2'($urandom_range(0, 3));
      w_din = 8'($urandom);
      exp_ny = ref_y(1, n_rst, n_en, n_a, {7'd0, n_din});
      exp_ns = ref_sel(n_rst, n_en, n_a);
      exp_wy = ref_y(8, w_rst, w_en, w_a, w_din);
      exp_ws = ref_sel(w_rst, w_en, w_a);
      tick();
      check("rand_narrow_y",   32'(n_y),   exp_ny);
      check("rand_narrow_sel", 32'(n_sel), 32'(exp_ns));
      check("rand_wide_y",     w_y,        exp_wy);
      check("rand_wide_sel",   32'(w_sel), 32'(exp_ws));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_4.md
# demux_4

Registered 1-to-4 demultiplexer: routes a WIDTH-bit data input onto one of four output lanes chosen by a 2-bit select, driving every unselected lane to zero. It sits between a single-source producer and four downstream consumers and provides a clean, glitch-free registered output. With WIDTH=1 and din=1, the Y output is the one-hot decode of A.

## Interface
Parameters:
- WIDTH, default 1: bit width of din and of each output lane.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  enable; when low, all lanes are driven to zero on the next edge.
- A  input  2  lane select; lane index 0..3 (A[1] is the MSB).
- din  input  WIDTH  data to route.
- Y  output  4*WIDTH  lane k occupies Y[k*WIDTH +: WIDTH], k=0..3.
- sel_oh  output  4  registered one-hot lane-active flags; bit k = 1 when lane k carried the routed data in the current output cycle.

## Operation
- Rising edge with rst=1: Y = 0, sel_oh = 0. Reset takes priority over en, A and din.
- Rising edge with rst=0 and en=1:
  - lane A ← din; the other three lanes ← 0.
  - sel_oh ← 4'b0001 << A.
- Rising edge with rst=0 and en=0: Y ← 0, sel_oh ← 0.
- sel_oh reflects the select, not the data: it is set for lane A even when din = 0.
- At all times, at most one lane is nonzero and sel_oh has at most one bit set.
- With WIDTH=1 and din=1, the output mapping is:
  - A=00 → Y=4'b0001
  - A=01 → Y=4'b0010
  - A=10 → Y=4'b0100
  - A=11 → Y=4'b1000
- No combinational path from any input to any output. Y and sel_oh are driven directly from flops.
- No internal state exists beyond the output registers. The block has no handshake and no backpressure.

## Timing
- Latency: exactly 1 clock. Inputs sampled at edge n appear on Y and sel_oh after edge n and hold until edge n+1.
- Throughput: one routing per cycle. A, din and en may change every cycle.
- A select change takes effect one cycle after it is sampled. The previously selected lane drops to 0 and the new lane takes din in the same cycle, with no overlap.
- Reset mid-operation: the cycle after the rst edge shows Y=0 and sel_oh=0 regardless of the inputs at that edge. Normal routing resumes on the first edge with rst=0.
- Before the first reset, output values are unspecified. The bench applies rst for at least 1 cycle at start.
- Simultaneous rst=1 and en=1: reset wins.

## Test plan
- Reset: WIDTH=1; hold rst=1 for 2 cycles with en=1, A=2, din=1 → Y=4'b0000 and sel_oh=4'b0000 on each cycle after reset.
- Select sweep: WIDTH=1, en=1, din=1; A=0,1,2,3 on consecutive cycles → Y = 0001, 0010, 0100, 1000 one cycle later each, with sel_oh equal to Y.
- Zero data: WIDTH=1, en=1, din=0, A=1 → Y=4'b0000 and sel_oh=4'b0010.
- Enable gating: WIDTH=1, din=1, A=3; en=1 then en=0 → Y=1000, then Y=0000 and sel_oh=0000.
- Wide data: WIDTH=8, en=1; drive A=2, din=8'hA5, then A=0, din=8'h3C → Y=32'h00A5_0000, then Y=32'h0000_003C, with no cycle showing both lanes nonzero.
- Mid-stream reset: WIDTH=1, en=1, din=1; A sweeps 0..3 and rst=1 is asserted in the cycle A=2 is applied → that output cycle shows Y=0000; the following cycle, with rst=0 and A=3, shows Y=1000.
